// File: rtl/fat32_cluster_chain_reader.sv
// Walks a FAT32 cluster chain and emits every data sector of the file in order.
// Latency: first data sector 2 cycles after start; one FAT sector fetch per cluster (cache hit: 1 cycle).
// Backpressure: dataSectorAddr held until dataSectorReady; sectorReq held until sectorAck.
// Optional macro FAT_SECTOR_CACHE_EN keeps the last fetched FAT sector to skip repeat reads.
module fat32_cluster_chain_reader #(
  parameter int theSizeofSectors = 512,
  parameter int ClusterLimit     = 65536
) (
  input  logic        Clock,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [31:0] StartCluster,
  input  logic [31:0] FATStartSector,
  input  logic [31:0] DataStartSector,
  input  logic [7:0]  SectorsPerCluster,
  output logic        sectorReq,
  output logic [31:0] sectorAddr,
  input  logic        sectorAck,
  input  logic        isEdit,
  input  logic [8:0]  EditAddress,
  input  logic [7:0]  EditByte,
  input  logic        blockDone,
  output logic        dataSectorValid,
  output logic [31:0] dataSectorAddr,
  input  logic        dataSectorReady,
  output logic        busy,
  output logic        chainEnd,
  output logic        chainError,
  output logic [31:0] clusterCount
);

  // Entries per FAT sector is a power of two; IDX_W bits of the cluster select the entry.
  localparam int          IDX_W         = $clog2(theSizeofSectors / 4);
  localparam int          BYTE_W        = IDX_W + 2;
  localparam logic [31:0] CLUSTER_LIMIT = 32'(ClusterLimit);

  typedef enum logic [2:0] {
    IDLE, EMIT, FETCH_REQ, FETCH_WAIT, CHECK, DONE, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       cluster_q;
  logic [31:0]       fat_start_q;
  logic [31:0]       data_start_q;
  logic [7:0]        spc_q;
  logic [7:0]        sec_idx_q;
  logic [31:0]       data_addr_q;
  logic              data_vld_q;
  logic [31:0]       count_q;
  logic              err_q;
  logic [31:0]       entry_q;

  logic [31:0]       fat_sec;
  logic [IDX_W-1:0]  entry_sel;
  logic [31:0]       next_cluster;
  logic              xfer;
  logic              last_sec;
  logic              is_eoc;
  logic              is_bad;
  logic              cache_hit;

  assign fat_sec      = fat_start_q + (cluster_q >> IDX_W);
  assign entry_sel    = cluster_q[IDX_W-1:0];
  assign next_cluster = {4'h0, entry_q[27:0]};
  assign xfer         = data_vld_q & dataSectorReady;
  assign last_sec     = (sec_idx_q == spc_q - 8'd1);
  assign is_eoc       = (next_cluster >= 32'h0FFF_FFF8);
  // A chain that reaches the limit is treated as looped, unless it ends right there.
  assign is_bad       = (next_cluster == 32'h0FFF_FFF7) || (next_cluster < 32'd2) ||
                        (count_q == CLUSTER_LIMIT);

`ifdef FAT_SECTOR_CACHE_EN
  logic [7:0]  cache_mem [theSizeofSectors];
  logic [31:0] cache_sec_q;
  logic        cache_vld_q;

  assign cache_hit = cache_vld_q && (cache_sec_q == fat_sec);

  // Mirror every byte of the sector being fetched; no reset needed, the valid bit guards it.
  always_ff @(posedge Clock) begin
    if (state_q == FETCH_WAIT && isEdit)
      cache_mem[EditAddress[BYTE_W-1:0]] <= EditByte;
  end

  // Cache tag: invalid from request until the sector has been fully delivered.
  always_ff @(posedge Clock) begin
    if (!sys_rst_n) begin
      cache_vld_q <= 1'b0;
      cache_sec_q <= 32'd0;
    end else if (state_q == IDLE && start) begin
      cache_vld_q <= 1'b0;
    end else if (state_q == FETCH_REQ && !cache_hit && sectorAck) begin
      cache_vld_q <= 1'b0;
      cache_sec_q <= fat_sec;
    end else if (state_q == FETCH_WAIT && blockDone) begin
      cache_vld_q <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    sectorReq  = 1'b0;
    sectorAddr = 32'd0;
    busy       = (state_q != IDLE);
    chainEnd   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (StartCluster < 32'd2) ? ERR : EMIT;
      end
      EMIT: begin
        if (xfer && last_sec) state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        sectorAddr = fat_sec;
        if (cache_hit) begin
          state_d = CHECK;
        end else begin
          sectorReq = 1'b1;
          if (sectorAck) state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (blockDone) state_d = CHECK;
      end
      CHECK: begin
        if (is_eoc)      state_d = DONE;
        else if (is_bad) state_d = ERR;
        else             state_d = EMIT;
      end
      DONE: begin
        chainEnd = 1'b1;
        state_d  = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latched walk parameters, sector emission, FAT entry capture, status.
  always_ff @(posedge Clock) begin
    if (!sys_rst_n) begin
      cluster_q    <= 32'd0;
      fat_start_q  <= 32'd0;
      data_start_q <= 32'd0;
      spc_q        <= 8'd0;
      sec_idx_q    <= 8'd0;
      data_addr_q  <= 32'd0;
      data_vld_q   <= 1'b0;
      count_q      <= 32'd0;
      err_q        <= 1'b0;
      entry_q      <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cluster_q    <= StartCluster;
            fat_start_q  <= FATStartSector;
            data_start_q <= DataStartSector;
            spc_q        <= SectorsPerCluster;
            count_q      <= 32'd0;
            err_q        <= 1'b0;
            data_vld_q   <= 1'b0;
          end
        end
        EMIT: begin
          // First cycle computes the cluster base; valid follows one cycle after entry.
          if (!data_vld_q) begin
            data_addr_q <= data_start_q + (cluster_q - 32'd2) * {24'd0, spc_q};
            sec_idx_q   <= 8'd0;
            data_vld_q  <= 1'b1;
          end else if (xfer) begin
            if (last_sec) begin
              data_vld_q <= 1'b0;
              count_q    <= count_q + 32'd1;
            end else begin
              data_addr_q <= data_addr_q + 32'd1;
              sec_idx_q   <= sec_idx_q + 8'd1;
            end
          end
        end
        FETCH_REQ: begin
`ifdef FAT_SECTOR_CACHE_EN
          if (cache_hit)
            entry_q <= {cache_mem[{entry_sel, 2'b11}], cache_mem[{entry_sel, 2'b10}],
                        cache_mem[{entry_sel, 2'b01}], cache_mem[{entry_sel, 2'b00}]};
          else if (sectorAck)
            entry_q <= 32'd0;
`else
          // Bytes never delivered read as zero, which classifies as an error.
          if (sectorAck) entry_q <= 32'd0;
`endif
        end
        FETCH_WAIT: begin
          if (isEdit && EditAddress[BYTE_W-1:2] == entry_sel)
            entry_q[EditAddress[1:0]*8 +: 8] <= EditByte;
        end
        CHECK: begin
          if (!is_eoc && !is_bad) cluster_q <= next_cluster;
        end
        ERR: begin
          err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dataSectorValid = data_vld_q;
  assign dataSectorAddr  = data_addr_q;
  assign chainError      = err_q;
  assign clusterCount    = count_q;

endmodule

// File: doc/fat32_cluster_chain_reader.md
FAT32_CLUSTER_CHAIN_READER -- requirements
Module: fat32_cluster_chain_reader

Interface
REQ-001 SHALL have parameter theSizeofSectors, default 512; bytes per sector (FAT32 entries per sector = theSizeofSectors/4).
REQ-002 SHALL have parameter ClusterLimit, default 65536; maximum clusters walked before the chain is declared looped.
REQ-003 Clock  input  1  sole clock; all logic on the rising edge.
REQ-004 sys_rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a chain walk.
REQ-006 StartCluster  input  32  first cluster of the file.
REQ-007 FATStartSector  input  32  absolute sector of FAT #1.
REQ-008 DataStartSector  input  32  absolute sector of cluster 2.
REQ-009 SectorsPerCluster  input  8  sectors per cluster; a power of two, 1..128.
REQ-010 sectorReq / sectorAddr  output  1 / 32  FAT sector read request to the SD block reader, and its absolute address.
REQ-011 sectorAck  input  1  reader accepts the request.
REQ-012 isEdit / EditAddress / EditByte  input  1 / 9 / 8  per-byte strobe, byte offset and data of the fetched sector.
REQ-013 blockDone  input  1  last byte of the fetched sector has been delivered.
REQ-014 dataSectorValid / dataSectorAddr  output  1 / 32  next file data sector to read.
REQ-015 dataSectorReady  input  1  consumer accepts dataSectorAddr.
REQ-016 busy / chainEnd / chainError / clusterCount  output  1 / 1 / 1 / 32  walk active; end-of-chain pulse; sticky error; clusters emitted.

Function
REQ-017 SHALL implement the states IDLE, EMIT, FETCH_REQ, FETCH_WAIT, CHECK and DONE/ERR.
REQ-018 In IDLE, start SHALL latch all inputs, clear chainError and clusterCount, and go to EMIT; start is ignored outside IDLE.
REQ-019 In IDLE, a StartCluster below 2 SHALL go to ERR.
REQ-020 In EMIT, dataSectorAddr SHALL be DataStartSector + (cluster-2)*SectorsPerCluster + i for i = 0..SectorsPerCluster-1, computed modulo 2^32.
REQ-021 In EMIT, dataSectorValid SHALL rise 1 cycle after entry, and the address SHALL be held stable until the valid&ready transfer.
REQ-022 After a transfer, the next address SHALL be presented on the following cycle.
REQ-023 After the last sector of a cluster transfers, clusterCount SHALL increment and the state SHALL go to FETCH_REQ.
REQ-024 In FETCH_REQ, sectorAddr SHALL be FATStartSector + (cluster >> 7), with the entry byte offset = cluster[6:0]*4.
REQ-025 sectorReq SHALL be held until the cycle in which sectorReq&sectorAck are both high, then the state SHALL go to FETCH_WAIT.
REQ-026 In FETCH_WAIT, on isEdit at EditAddress = offset..offset+3, EditByte SHALL be captured little-endian; other bytes are ignored.
REQ-027 In FETCH_WAIT, blockDone SHALL move the state to CHECK.
REQ-028 In CHECK, the next-cluster value SHALL be the captured entry with bits [31:28] masked.
REQ-029 CHECK classification: 0x0FFFFFF8–0x0FFFFFFF -> DONE.
REQ-030 CHECK classification: 0x0FFFFFF7, 0, 1, or clusterCount = ClusterLimit -> ERR.
REQ-031 CHECK classification: any other value becomes the current cluster and the state goes to EMIT.
REQ-032 DONE SHALL pulse chainEnd for 1 cycle and return to IDLE.
REQ-033 ERR SHALL set chainError (held until the next start or reset) and return to IDLE.
REQ-034 busy SHALL be high in every state except IDLE.

Reset
REQ-035 sys_rst_n low at a clock edge SHALL force IDLE and drive all outputs to 0, including mid-handshake.
REQ-036 An in-flight FAT byte stream after reset SHALL be ignored.

Configuration
REQ-037 Macro FAT_SECTOR_CACHE_EN, when defined, SHALL store the full fetched FAT sector (theSizeofSectors bytes) plus its sector number and a valid bit.
REQ-038 With FAT_SECTOR_CACHE_EN, a FETCH_REQ whose sector equals the cached sector SHALL skip sectorReq and go to CHECK after 1 lookup cycle.
REQ-039 With FAT_SECTOR_CACHE_EN, reset and start SHALL invalidate the cache.
REQ-040 Without FAT_SECTOR_CACHE_EN, every FAT lookup SHALL issue sectorReq and no sector buffer SHALL exist.

Verification
REQ-041 SPC=8, DataStart=0x4000, FATStart=0x20, StartCluster=5, entry bytes at 0x14 = FF FF FF 0F -> dataSectorAddr 0x4018..0x401F, one sectorReq at 0x20, chainEnd pulse, clusterCount=1.
REQ-042 Same setup, entry 5 = 06 00 00 F0, entry 6 = FF FF FF 0F -> next cluster 6, 16 contiguous addresses 0x4018..0x4027.
REQ-043 REQ-042 chain FAT fetches -> two fetches at sector 0x20 without FAT_SECTOR_CACHE_EN, one fetch with it.
REQ-044 StartCluster=130 -> sectorAddr=0x21, bytes captured from offsets 0x08..0x0B.
REQ-045 Entry F7 FF FF 0F -> chainError=1, no chainEnd; a later start clears chainError.
REQ-046 dataSectorReady low 5 cycles -> dataSectorValid=1 with dataSectorAddr unchanged.
REQ-047 sys_rst_n low while sectorReq=1 -> next cycle sectorReq=0, busy=0, all outputs 0.
